// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL reset pulse, lock qualification and core reset release sequencer
module pll_reset_seq #(
   parameter int RST_PULSE    = 16,
   parameter int LOCK_STABLE  = 1024,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int RST_EXT      = 256
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       pll_locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       core_reset,
   output logic       ready,
   output logic       lock_lost,
   output logic [3:0] retry_count
);
   localparam int M1 = RST_PULSE > LOCK_STABLE ? RST_PULSE : LOCK_STABLE;
   localparam int M2 = LOCK_TIMEOUT > RST_EXT ? LOCK_TIMEOUT : RST_EXT;
   localparam int MAXP = M1 > M2 ? M1 : M2;
   localparam int CW = MAXP > 2 ? $clog2(MAXP) : 1;
   localparam logic [CW-1:0] T_RP = CW'(RST_PULSE - 1);
   localparam logic [CW-1:0] T_LS = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] T_LT = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] T_RE = CW'(RST_EXT - 1);
   localparam logic [2:0] S_RST  = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_STAB = 3'd2;
   localparam logic [2:0] S_EXT  = 3'd3;
   localparam logic [2:0] S_RUN  = 3'd4;

   logic          lock_m, lock_s;
   logic [2:0]    state, nxt;
   logic [CW-1:0] cnt;
   logic          entry, timeout, lost_ev;

   // next state; relock_req overrides every lock_s event
   always_comb begin
      nxt = state;
      timeout = 1'b0;
      lost_ev = 1'b0;
      if (relock_req) nxt = S_RST;
      else case (state)
         S_RST:  if (cnt == T_RP) nxt = S_WAIT;
         S_WAIT: begin
            if (lock_s) nxt = S_STAB;
            else if (cnt == T_LT) begin
               nxt = S_RST;
               timeout = 1'b1;
            end
         end
         S_STAB: nxt = !lock_s ? S_WAIT : (cnt == T_LS ? S_EXT : S_STAB);
         S_EXT:  nxt = !lock_s ? S_WAIT : (cnt == T_RE ? S_RUN : S_EXT);
         S_RUN:  begin
            if (!lock_s) begin
               nxt = S_RST;
               lost_ev = 1'b1;
            end
         end
         default: nxt = S_RST;
      endcase
      entry = relock_req || (nxt != state);
   end

   // synchronizer, state/counter and outputs decoded from the next state
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
         state <= S_RST;
         cnt <= '0;
         pll_rst <= 1'b1;
         core_reset <= 1'b1;
         ready <= 1'b0;
         lock_lost <= 1'b0;
         retry_count <= 4'd0;
      end else begin
         lock_m <= pll_locked;
         lock_s <= lock_m;
         state <= nxt;
         cnt <= entry ? '0 : (state == S_RUN ? cnt : cnt + 1'b1);
         pll_rst <= nxt == S_RST;
         core_reset <= nxt != S_RUN;
         ready <= nxt == S_RUN;
         if (lost_ev) lock_lost <= 1'b1;
         if (timeout && retry_count != 4'd15) retry_count <= retry_count + 4'd1;
      end
   end
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: randomized segments of lock/relock/reset activity against a timestamp-style model
module tb_pll_reset_seq;
   localparam int RP = 4, LS = 8, LT = 32, RE = 4;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic       pll_locked = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_rst, core_reset, ready, lock_lost;
   logic [3:0] retry_count;

   int checks = 0;
   int passed = 0;

   // model: remaining reset-pulse cycles, cycles waited, cycles of good lock (-1 = none)
   int m_p, m_wait, m_good, m_retry;
   bit m_lost, s1, s2;

   pll_reset_seq #(.RST_PULSE(RP), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .RST_EXT(RE)) dut (
      .clk_sys(clk_sys), .reset(reset), .pll_locked(pll_locked), .relock_req(relock_req),
      .pll_rst(pll_rst), .core_reset(core_reset), .ready(ready),
      .lock_lost(lock_lost), .retry_count(retry_count)
   );

   always #10 clk_sys = ~clk_sys;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // reference model advanced on each rising edge
   always @(posedge clk_sys) begin : model
      bit ls;
      ls = s2;
      s2 = s1;
      s1 = pll_locked;
      if (reset) begin
         s1 = 1'b0;
         s2 = 1'b0;
         m_p = RP;
         m_wait = 0;
         m_good = -1;
         m_retry = 0;
         m_lost = 1'b0;
      end else if (relock_req) begin
         m_p = RP;
         m_good = -1;
      end else if (m_p > 0) begin
         m_p--;
         m_wait = 0;
      end else if (m_good < 0) begin
         if (ls) m_good = 0;
         else if (m_wait == LT - 1) begin
            m_p = RP;
            m_retry = m_retry < 15 ? m_retry + 1 : 15;
         end else m_wait++;
      end else if (!ls) begin
         if (m_good >= LS + RE) begin
            m_p = RP;
            m_lost = 1'b1;
         end else m_wait = 0;
         m_good = -1;
      end else if (m_good < LS + RE) m_good++;
   end

   initial begin
      int mode, left, pos;
      bit exp_ready;
      left = 0;
      pos = 0;
      mode = 0;
      for (int cyc = 0; cyc < 16000; cyc++) begin
         @(negedge clk_sys);
         exp_ready = m_p == 0 && m_good >= LS + RE;
         check("pll_rst", int'(pll_rst), int'(m_p > 0));
         check("ready", int'(ready), int'(exp_ready));
         check("core_reset", int'(core_reset), int'(!exp_ready));
         check("lock_lost", int'(lock_lost), int'(m_lost));
         check("retry_count", int'(retry_count), m_retry);
         if (left == 0) begin
            mode = $urandom_range(0, 5);
            case (mode)
               0: left = $urandom_range(20, 300);
               1: left = $urandom_range(3, 50);
               2: left = $urandom_range(5, 40);
               3: left = 600;
               4: left = 40;
               default: left = 50;
            endcase
            pos = 0;
         end
         relock_req = 1'b0;
         case (mode)
            0: begin
               pll_locked = 1'b1;
               relock_req = $urandom_range(0, 199) == 0;
            end
            1: pll_locked = 1'b0;
            2: pll_locked = 1'($urandom_range(0, 1));
            3: pll_locked = 1'b0;
            4: begin
               pll_locked = 1'b1;
               relock_req = pos < 6;
            end
            default: begin
               pll_locked = pos < 30;
               relock_req = pos == 32;
            end
         endcase
         reset = cyc < 2 || $urandom_range(0, 2999) == 0 ||
                 (m_p == 0 && m_good >= LS && m_good < LS + RE && $urandom_range(0, 39) == 0);
         left--;
         pos++;
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 The module SHALL have parameter RST_PULSE, default 16: clk_sys cycles pll_rst is held high per attempt.
REQ-002 The module SHALL have parameter LOCK_STABLE, default 1024: cycles synchronized lock must stay high before release.
REQ-003 The module SHALL have parameter LOCK_TIMEOUT, default 65536: cycles waited for lock before a retry.
REQ-004 The module SHALL have parameter RST_EXT, default 256: extra cycles core_reset stays high after lock is stable.
REQ-005 The module SHALL have port clk_sys  input  1  the single clock (free-running 50 MHz reference); all logic on its rising edge.
REQ-006 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 The module SHALL have port pll_locked  input  1  PLL locked flag, asynchronous to clk_sys.
REQ-008 The module SHALL have port relock_req  input  1  single-cycle request to re-run the lock sequence (e.g. after a video-standard change).
REQ-009 The module SHALL have port pll_rst  output  1  reset to the PLL.
REQ-010 The module SHALL have port core_reset  output  1  reset to the Apple II core clock domain consumers.
REQ-011 The module SHALL have port ready  output  1  high only when clocks are locked and the core is released.
REQ-012 The module SHALL have port lock_lost  output  1  sticky flag: lock dropped while in RUN.
REQ-013 The module SHALL have port retry_count  output  4  number of lock timeouts, saturating at 15.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer (lock_s); all decisions use lock_s only, so input-to-decision latency is 2 cycles.
REQ-015 FSM states SHALL be PLL_RST, WAIT_LOCK, STABLE, EXTEND, RUN, with one shared cycle counter cleared on every state entry.
REQ-016 All outputs SHALL be registered and change on the cycle following the state entry that drives them.
REQ-017 PLL_RST: pll_rst=1, core_reset=1, ready=0; after exactly RST_PULSE cycles -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0, core_reset=1; lock_s=1 -> STABLE; counter reaching LOCK_TIMEOUT-1 with lock_s=0 -> PLL_RST and retry_count increments (saturates at 15).
REQ-019 STABLE: lock_s=0 -> WAIT_LOCK (timeout restarts from 0); counter reaching LOCK_STABLE-1 with lock_s=1 -> EXTEND.
REQ-020 EXTEND: core_reset=1; lock_s=0 -> WAIT_LOCK; counter reaching RST_EXT-1 -> RUN.
REQ-021 RUN: core_reset=0, ready=1; lock_s=0 -> PLL_RST and lock_lost set; core_reset re-asserts and ready drops the cycle after the drop is seen.
REQ-022 relock_req=1 in any state SHALL force PLL_RST with cleared counter next cycle; it has priority over all lock_s events; it does not set lock_lost or change retry_count.
REQ-023 relock_req held high SHALL keep the FSM in PLL_RST with pll_rst=1 continuously.
REQ-024 Counter width SHALL cover the largest parameter; no wrap-around before a terminal count is reached.
REQ-025 lock_lost and retry_count SHALL clear only on reset.

Reset
REQ-026 On reset=1 (any state, including mid-sequence), next edge SHALL give: state PLL_RST, counter 0, synchronizer 0, pll_rst=1, core_reset=1, ready=0, lock_lost=0, retry_count=0.
REQ-027 Release of reset SHALL start a full PLL_RST pulse of RST_PULSE cycles.

Verification (RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, RST_EXT=4)
REQ-028 Clean start: reset released, pll_locked rises 10 cycles later and stays -> pll_rst high 4 cycles, ready=1 and core_reset=0 after 2+8+4 cycles from lock, retry_count=0.
REQ-029 Timeout: pll_locked held 0 -> pll_rst re-pulses every 4+32 cycles, retry_count 1,2,... saturating at 15, ready stays 0.
REQ-030 Glitch in STABLE: lock high 5 cycles, low 1, high again -> returns to WAIT_LOCK, release occurs 8+4 cycles after the final rise is synchronized.
REQ-031 Loss in RUN: pll_locked drops -> within 3 cycles core_reset=1, ready=0, pll_rst=1 for 4 cycles, lock_lost=1 and it stays 1 after relock.
REQ-032 relock_req pulse in RUN -> PLL_RST entered next cycle, lock_lost stays 0, retry_count unchanged; simultaneous relock_req and lock drop -> lock_lost stays 0.
REQ-033 Reset asserted during EXTEND -> all outputs at reset values next cycle and the sequence restarts from PLL_RST.
